yuv422_to_rgb888_converter: RTL and testbench
=============================================

# yuv422_to_rgb888_converter

Frame-level colour-space converter for the SRAM image pipeline: walks a W×H frame of packed 4:2:2 YUV stored in SRAM and writes packed 24-bit RGB back to a second SRAM region. Successor to the fixed-size single-matrix converter. Adds:
- parametrised frame geometry and base addresses,
- a run-time selectable BT.601/BT.709 coefficient set,
- explicit saturation,
- a busy/done handshake.

## Interface
- W, 320, frame width in pixels (even)
- H, 240, frame height in lines
- DW, 16, SRAM data width (fixed 16 in this revision)
- AW, 18, SRAM address width
- ADDR_YUV, 0, base word address of YUV input
- ADDR_RGB, 76800, base word address of RGB output
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  frame start request, sampled only in IDLE
- mode  in  1  0 = BT.601, 1 = BT.709; latched on accepted start
- busy  out  1  high from accepted start until DONE
- done  out  1  one-cycle pulse after last write of frame
- raddr  out  AW  SRAM read address
- rdata  in  DW  SRAM read data, valid one cycle after raddr
- waddr  out  AW  SRAM write address
- wdata  out  DW  SRAM write data
- wr_enable  out  1  SRAM write strobe

## Operation
- Input layout, pixel pair p (0 ≤ p < W·H/2):
  - word ADDR_YUV+2p = {Y0[15:8], Y1[7:0]}
  - word ADDR_YUV+2p+1 = {U[15:8], V[7:0]}
- Output layout per pair:
  - ADDR_RGB+3p = {R0, G0}
  - ADDR_RGB+3p+1 = {B0, R1}
  - ADDR_RGB+3p+2 = {G1, B1}
- FSM states: IDLE, RD_Y, RD_UV, CAP_UV, CALC, WR0, WR1, WR2, DONE.
  - IDLE → RD_Y when start=1.
  - RD_Y → RD_UV → CAP_UV → CALC → WR0 → WR1 → WR2.
  - WR2 → RD_Y if pairs remain, else DONE.
  - DONE → IDLE.
- Register updates:
  - RD_Y drives raddr = Y word.
  - RD_UV drives raddr = UV word and captures the Y word at the end of the cycle.
  - CAP_UV captures the UV word.
  - CALC registers six 8-bit results.
  - WRk drives the k-th output word with wr_enable=1.
- Pair counter: clears on accepted start; increments in WR2.
- Arithmetic, per pixel:
  - Signed offsets: y = Y−16, u = U−128, v = V−128, each 9-bit signed.
  - R = a·y + b·v
  - G = a·y − d·v − c·u
  - B = a·y + e·u
  - Coefficients are unsigned Q16, 18 bits. Accumulators are 32-bit signed.
  - Result = arithmetic shift right by 16 (floor), then clamp to [0,255].
- Coefficients:
  - BT.601: a=76284, b=104595, c=25624, d=53281, e=132251.
  - BT.709: a=76284, b=117440, c=13959, d=34928, e=138412.
- start while busy: ignored, no effect on the frame in progress.
- mode changes after start: ignored until the next accepted start.
- reset at any time:
  - FSM → IDLE, counter cleared.
  - Outputs go to reset values the next cycle; no further writes are issued.
  - The partially written frame is not completed.
- Reset values: busy=0, done=0, raddr=0, waddr=0, wdata=0, wr_enable=0. All outputs are registered or decoded from registered state.

## Timing
- Cycle 0 is the edge where start is sampled in IDLE. RD_Y is active in cycle 1.
- Each pair takes 7 cycles (RD_Y…WR2).
  - Pair p occupies cycles 1+7p … 7+7p.
  - WR0 is in cycle 5+7p.
- DONE is in cycle 1+7·W·H/2; done=1 and busy=0 in that cycle.
- IDLE follows the next cycle, so back-to-back start is accepted one cycle after done.
- busy=1 in cycles 1 … 7·W·H/2.
- wr_enable is high exactly 3 cycles per pair and never in any other state.
- waddr and wdata are stable whenever wr_enable=1.
- raddr holds its last value outside RD_Y/RD_UV.

## Configuration
- YUV2RGB_BT709_EN defined:
  - mode input honoured.
  - The BT.709 coefficient set is compiled in.
- YUV2RGB_BT709_EN undefined:
  - mode port is present but ignored; BT.601 is always used.
  - BT.709 constants and the select mux are removed.

## Test plan
- Single pair W=2,H=1, Y0=16, Y1=235, U=V=128, BT.601 → writes {0x00,0x00}, {0x00,0xFE}, {0xFE,0xFE} at ADDR_RGB..+2; done pulses in cycle 8.
- Saturation: Y0=Y1=255, U=V=255, BT.601 → R=255, G=125, B=255. Y=0, U=V=128 → R=G=B=0 (−19 clamped).
- Mode: Y=16, U=128, V=255 → R=202 with mode=0, R=227 with mode=1 (macro defined); R=202 for both when macro undefined.
- Frame W=4,H=2 → busy high for 28 cycles; exactly 12 writes at ADDR_RGB..ADDR_RGB+11 in ascending order; reads cover ADDR_YUV..+7 only.
- reset asserted in WR1 of pair 1 → wr_enable=0 from next cycle; no writes after; busy=0, done never pulses; a new start runs the full frame from pair 0.
- start held high continuously → frames run back-to-back with one IDLE cycle between done and the next RD_Y; start pulses during busy are ignored.

Source files
------------

// File: rtl/yuv422_to_rgb888_converter.sv
// Frame-level packed YUV 4:2:2 to packed RGB888 converter that walks SRAM one pixel pair at a time.
// Define YUV2RGB_BT709_EN to honour the mode input (BT.709); otherwise BT.601 is always used.
module yuv422_to_rgb888_converter #(
  parameter int W        = 320,
  parameter int H        = 240,
  parameter int DW       = 16,
  parameter int AW       = 18,
  parameter int ADDR_YUV = 0,
  parameter int ADDR_RGB = 76800
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          wr_enable
);

  localparam int NPAIRS = W * H / 2;
  localparam int PCW    = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;

  typedef enum logic [3:0] {
    IDLE, RD_Y, RD_UV, CAP_UV, CALC, WR0, WR1, WR2, DONE
  } state_t;

  // Unsigned Q16 coefficients.
  typedef struct packed {
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] c;
    logic [17:0] d;
    logic [17:0] e;
  } coef_t;

  localparam coef_t BT601 = '{a: 18'd76284, b: 18'd104595, c: 18'd25624,
                              d: 18'd53281, e: 18'd132251};

  state_t         state, next_state;
  logic [PCW-1:0] pair_cnt;
  logic [AW-1:0]  wr_base;
  logic           last_pair;
  logic [15:0]    y_word, uv_word;
  logic [7:0]     r0, g0, b0, r1, g1, b1;
  logic [23:0]    pix0, pix1;
  coef_t          coef_sel;

`ifdef YUV2RGB_BT709_EN
  localparam coef_t BT709 = '{a: 18'd76284, b: 18'd117440, c: 18'd13959,
                              d: 18'd34928, e: 18'd138412};
  logic mode_q;

  assign coef_sel = mode_q ? BT709 : BT601;
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign coef_sel    = BT601;
`endif

  assign last_pair = (pair_cnt == PCW'(NPAIRS - 1));

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RD_Y;
      RD_Y:    next_state = RD_UV;
      RD_UV:   next_state = CAP_UV;
      CAP_UV:  next_state = CALC;
      CALC:    next_state = WR0;
      WR0:     next_state = WR1;
      WR1:     next_state = WR2;
      WR2:     next_state = last_pair ? DONE : RD_Y;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pair_cnt <= '0;
      raddr    <= '0;
      wr_base  <= '0;
`ifdef YUV2RGB_BT709_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (start) begin
          pair_cnt <= '0;
          raddr    <= AW'(ADDR_YUV);
          wr_base  <= AW'(ADDR_RGB);
`ifdef YUV2RGB_BT709_EN
          mode_q   <= mode;
`endif
        end
        // raddr is the running read pointer: Y word in RD_Y, UV word in RD_UV.
        RD_Y: raddr <= raddr + AW'(1);
        WR2: begin
          pair_cnt <= pair_cnt + PCW'(1);
          wr_base  <= wr_base + AW'(3);
          if (!last_pair) raddr <= raddr + AW'(1);
        end
        default: ;
      endcase
    end
  end

  function automatic logic [7:0] sat8(input logic signed [31:0] acc);
    logic signed [15:0] q;
    q = acc[31:16];
    if (q < 0)              return 8'd0;
    else if (q > 16'sd255)  return 8'd255;
    else                    return q[7:0];
  endfunction

  function automatic logic [23:0] yuv_pixel(input logic [7:0] y8, input logic [7:0] u8,
                                            input logic [7:0] v8, input coef_t k);
    logic signed [8:0]  ys, us, vs;
    logic signed [31:0] ya, r_acc, g_acc, b_acc;
    ys    = $signed({1'b0, y8}) - 9'sd16;
    us    = $signed({1'b0, u8}) - 9'sd128;
    vs    = $signed({1'b0, v8}) - 9'sd128;
    ya    = 32'(ys) * $signed({14'd0, k.a});
    r_acc = ya + 32'(vs) * $signed({14'd0, k.b});
    g_acc = ya - 32'(vs) * $signed({14'd0, k.d}) - 32'(us) * $signed({14'd0, k.c});
    b_acc = ya + 32'(us) * $signed({14'd0, k.e});
    return {sat8(r_acc), sat8(g_acc), sat8(b_acc)};
  endfunction

  assign pix0 = yuv_pixel(y_word[15:8], uv_word[15:8], uv_word[7:0], coef_sel);
  assign pix1 = yuv_pixel(y_word[7:0],  uv_word[15:8], uv_word[7:0], coef_sel);

  // NOTE: datapath registers carry no reset; each is written before the state that consumes it.
  always_ff @(posedge clk) begin
    case (state)
      RD_UV:   y_word  <= rdata[15:0];
      CAP_UV:  uv_word <= rdata[15:0];
      CALC: begin
        {r0, g0, b0} <= pix0;
        {r1, g1, b1} <= pix1;
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign wr_enable = (state == WR0) || (state == WR1) || (state == WR2);

  always_comb begin
    waddr = '0;
    wdata = '0;
    case (state)
      WR0: begin
        waddr = wr_base;
        wdata = DW'({r0, g0});
      end
      WR1: begin
        waddr = wr_base + AW'(1);
        wdata = DW'({b0, r1});
      end
      WR2: begin
        waddr = wr_base + AW'(2);
        wdata = DW'({g1, b1});
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_yuv422_to_rgb888_converter.sv
// Directed bench for yuv422_to_rgb888_converter on a 4x2 frame with a small SRAM model.
module tb_yuv422_to_rgb888_converter;

  localparam int AW     = 18;
  localparam int A_YUV  = 8;
  localparam int A_RGB  = 40;

  logic          clk = 1'b0;
  logic          reset, start, mode;
  logic          busy, done, wr_enable;
  logic [AW-1:0] raddr, waddr;
  logic [15:0]   rdata, wdata;

  yuv422_to_rgb888_converter #(
    .W(4), .H(2), .DW(16), .AW(AW), .ADDR_YUV(A_YUV), .ADDR_RGB(A_RGB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done), .raddr(raddr), .rdata(rdata),
    .waddr(waddr), .wdata(wdata), .wr_enable(wr_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y0, y1, u, v;
    logic [7:0] r0, g0, b0, r1, g1, b1;
  } vec_t;

  typedef struct {
    int addr;
    int data;
    int c;
  } wr_t;

  logic [15:0] mem [0:255];
  vec_t        tab_a [4];
  vec_t        tab_b [4];
  vec_t        cur   [4];
  wr_t         wlog  [$];
  wr_t         wentry;
  int          cyc = 0;
  int          base;
  bit          read_oob;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rdata <= mem[raddr[7:0]];
  end

  always @(negedge clk) begin
    if (wr_enable) begin
      wentry.addr = int'(waddr);
      wentry.data = int'(wdata);
      wentry.c    = cyc;
      wlog.push_back(wentry);
    end
    if (busy && (int'(raddr) < A_YUV || int'(raddr) > A_YUV + 7)) read_oob = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int y0, y1, u, v, r0, g0, b0, r1, g1, b1);
    vec_t t;
    t.y0 = 8'(y0); t.y1 = 8'(y1); t.u = 8'(u); t.v = 8'(v);
    t.r0 = 8'(r0); t.g0 = 8'(g0); t.b0 = 8'(b0);
    t.r1 = 8'(r1); t.g1 = 8'(g1); t.b1 = 8'(b1);
    return t;
  endfunction

  task automatic load_frame(input bit use_b);
    for (int p = 0; p < 4; p++) begin
      cur[p] = use_b ? tab_b[p] : tab_a[p];
      mem[A_YUV + 2*p]     = {cur[p].y0, cur[p].y1};
      mem[A_YUV + 2*p + 1] = {cur[p].u, cur[p].v};
    end
  endtask

  // Starts a frame at the next edge (cycle 0) and returns in the DONE cycle.
  task automatic run_frame(input logic m, input bit hold, input bit poke,
                           output int done_cyc, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; mode = m; base = cyc; wlog.delete(); read_oob = 1'b0;
    done_cyc = -1; busy_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) start = 1'b0;
      if (poke) begin
        if (k == 3) mode = ~m;
        if (k == 10 || k == 20) start = 1'b1;
        if (k == 11 || k == 21) start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = k;
        check("busy_low_in_done", int'(busy), 0);
        break;
      end
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, wlog.size(), 12);
    for (int i = 0; i < 12 && i < wlog.size(); i++) begin
      int p, j, ew;
      p = i / 3;
      j = i % 3;
      case (j)
        0:       ew = int'({cur[p].r0, cur[p].g0});
        1:       ew = int'({cur[p].b0, cur[p].r1});
        default: ew = int'({cur[p].g1, cur[p].b1});
      endcase
      check($sformatf("%s_waddr%0d", tag, i), wlog[i].addr, A_RGB + i);
      check($sformatf("%s_wdata%0d", tag, i), wlog[i].data, ew);
      check($sformatf("%s_wcycle%0d", tag, i), wlog[i].c - base, 5 + 7*p + j);
    end
    check({tag, "_read_window"}, int'(read_oob), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc, bc, wcount, dcount;

    tab_a[0] = mk( 16, 235, 128, 128,    0,   0,   0,  254, 254, 254);
    tab_a[1] = mk(255,   0, 255, 255,  255, 125, 255,  184,   0, 237);
    tab_a[2] = mk(  0, 126, 128, 128,    0,   0,   0,  128, 128, 128);
    tab_a[3] = mk( 16,  16, 128, 255,  202,   0,   0,  202,   0,   0);
`ifdef YUV2RGB_BT709_EN
    tab_b[0] = mk( 16,  16, 128, 255,  227,   0,   0,  227,   0,   0);
    tab_b[2] = mk(126, 126,   0, 128,  128, 155,   0,  128, 155,   0);
    tab_b[3] = mk( 16,  16, 200, 128,    0,   0, 152,    0,   0, 152);
`else
    tab_b[0] = mk( 16,  16, 128, 255,  202,   0,   0,  202,   0,   0);
    tab_b[2] = mk(126, 126,   0, 128,  128, 178,   0,  128, 178,   0);
    tab_b[3] = mk( 16,  16, 200, 128,    0,   0, 145,    0,   0, 145);
`endif
    tab_b[1] = mk(235, 235, 128, 128,  254, 254, 254,  254, 254, 254);

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);
    check("rst_raddr", int'(raddr), 0);
    check("rst_waddr", int'(waddr), 0);
    check("rst_wdata", int'(wdata), 0);
    check("rst_wr_enable", int'(wr_enable), 0);
    reset = 1'b0;

    // Frame A, BT.601: basic, saturating and clamped-to-zero pixels.
    load_frame(1'b0);
    run_frame(1'b0, 1'b0, 1'b0, dc, bc);
    check("a_done_cycle", dc, 29);
    check("a_busy_cycles", bc, 28);
    check_writes("a");
    @(negedge clk);
    check("a_done_one_cycle", int'(done), 0);
    check("a_idle_after_done", int'(busy), 0);

    // Frame B with mode=1, then mode flips and stray start pulses mid-frame.
    load_frame(1'b1);
    run_frame(1'b1, 1'b0, 1'b1, dc, bc);
    check("b_done_cycle", dc, 29);
    check("b_busy_cycles", bc, 28);
    check_writes("b");
    mode = 1'b0;

    // Reset asserted during WR1 of pair 1 (cycle 13).
    load_frame(1'b0);
    @(negedge clk);
    start = 1'b1; base = cyc; wlog.delete();
    dcount = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) dcount++;
      if (k == 13) begin
        check("rst_mid_wr1_enable", int'(wr_enable), 1);
        check("rst_mid_wr1_addr", int'(waddr), A_RGB + 4);
        reset = 1'b1;
      end
      if (k == 14) begin
        check("rst_mid_wr_enable_off", int'(wr_enable), 0);
        check("rst_mid_busy_off", int'(busy), 0);
        check("rst_mid_raddr", int'(raddr), 0);
        reset = 1'b0;
      end
    end
    check("rst_mid_writes", wlog.size(), 5);
    check("rst_mid_no_done", dcount, 0);
    run_frame(1'b0, 1'b0, 1'b0, dc, bc);
    check("after_rst_done_cycle", dc, 29);
    check_writes("after_rst");

    // start held high: frames run back to back with one IDLE cycle in between.
    run_frame(1'b0, 1'b1, 1'b0, dc, bc);
    check("hold_done1_cycle", dc, 29);
    @(negedge clk);
    check("hold_idle_gap_busy", int'(busy), 0);
    check("hold_idle_gap_done", int'(done), 0);
    @(negedge clk);
    check("hold_second_start_busy", int'(busy), 1);
    dc = -1;
    for (int k = 31; k <= 120; k++) begin
      if (done) begin
        dc = k;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("hold_done2_cycle", dc, 59);
    wcount = wlog.size();
    check("hold_total_writes", wcount, 24);
    repeat (3) @(negedge clk);
    check("hold_stops_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
